// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared definitions for the elastic pipeline register.
//   slot_state_t : per-slot occupancy state (EMPTY=0, ONE=1, TWO=2); the
//                  encoding equals the number of entries held, so the
//                  occupancy adder can sum the states directly.
//   occ_width()  : width of the occupancy port for a given DEPTH/SKID.
package pipe_pkg;

  typedef enum logic [1:0] {
    SLOT_EMPTY = 2'd0,
    SLOT_ONE   = 2'd1,
    SLOT_TWO   = 2'd2
  } slot_state_t;

  // max(1, $clog2(depth * entries_per_slot + 1))
  function automatic int occ_width(input int depth, input int skid);
    int max_occ;
    int w;
    max_occ = depth * ((skid != 0) ? 2 : 1);
    w       = $clog2(max_occ + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot
// One stage of the elastic pipeline: valid/ready register with an optional
// skid entry.
//   clock, reset              : rising-edge clock, async active-high reset
//   flush                     : synchronous discard, forces in_ready low
//   in_valid/in_ready/in_data : upstream handshake
//   out_valid/out_ready/out_data : downstream handshake (BUBBLE when idle)
//   slot_state                : current state, summed by the top for occupancy
//
// state      | meaning
// -----------+----------------------------------------------------------
// SLOT_EMPTY | nothing held, ready to accept
// SLOT_ONE   | main register valid and driving out_data
// SLOT_TWO   | main and skid both valid (SKID=1 only), in_ready low
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter int               SKID   = 1,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output slot_state_t      slot_state
);

  slot_state_t      state_q;
  slot_state_t      state_nxt;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             load_main;
  logic             main_from_skid;
  logic             load_skid;
  logic             accept;
  logic             take;

  assign accept = in_valid & in_ready;
  assign take   = out_valid & out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= SLOT_EMPTY;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) begin
        main_q <= main_from_skid ? skid_q : in_data;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

  // With SKID=0 the ONE->TWO arc is unreachable: in_ready in ONE requires
  // out_ready, so any accept in ONE coincides with a take.
  always_comb begin
    state_nxt      = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_nxt = SLOT_EMPTY;
    end else begin
      case (state_q)
        SLOT_EMPTY: begin
          if (accept) begin
            state_nxt = SLOT_ONE;
            load_main = 1'b1;
          end
        end
        SLOT_ONE: begin
          if (take && accept) begin
            load_main = 1'b1;
          end else if (take) begin
            state_nxt = SLOT_EMPTY;
          end else if (accept) begin
            state_nxt = SLOT_TWO;
            load_skid = 1'b1;
          end
        end
        SLOT_TWO: begin
          if (take) begin
            state_nxt      = SLOT_ONE;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_nxt = SLOT_EMPTY;
      endcase
    end
  end

  // in_ready is held low during reset so nothing is accepted while the
  // slot is being cleared.
  always_comb begin
    out_valid  = (state_q != SLOT_EMPTY);
    out_data   = out_valid ? main_q : BUBBLE;
    slot_state = state_q;
    if (SKID != 0) begin
      in_ready = !reset && !flush && (state_q != SLOT_TWO);
    end else begin
      in_ready = !reset && !flush && ((state_q == SLOT_EMPTY) || out_ready);
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic
// Elastic pipeline register: WIDTH-bit payload through DEPTH chained
// pipe_slot stages with valid/ready handshake, optional skid buffering,
// synchronous flush and a bubble value on idle output.
//   clock, reset              : rising-edge clock, async active-high reset
//   flush                     : synchronous discard of all stored entries
//   in_valid/in_ready/in_data : upstream handshake
//   out_valid/out_ready/out_data : downstream handshake
//   occupancy                 : number of entries currently held
// DEPTH=0 is a pure wire-through; reset, flush and BUBBLE have no effect.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter int               DEPTH  = 1,
  parameter int               SKID   = 1,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  localparam int              OCC_W  = occ_width(DEPTH, SKID)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  if (DEPTH == 0) begin : g_pass
    assign out_valid = in_valid;
    assign in_ready  = out_ready;
    assign out_data  = in_data;
    assign occupancy = '0;

    logic unused_ctrl;
    assign unused_ctrl = clock ^ reset ^ flush;
  end else begin : g_pipe
    logic             valid_b [DEPTH+1];
    logic [WIDTH-1:0] data_b  [DEPTH+1];
    slot_state_t      st      [DEPTH];

    assign valid_b[0] = in_valid;
    assign data_b[0]  = in_data;
    assign out_valid  = valid_b[DEPTH];
    assign out_data   = data_b[DEPTH];

    // Ready runs backwards through per-slot signals rather than one shared
    // vector, so the SKID=0 combinational chain is a clean acyclic path.
    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
      logic rdy_in;
      logic rdy_out;

      if (k == DEPTH - 1) begin : g_last
        assign rdy_out = out_ready;
      end else begin : g_mid
        assign rdy_out = g_slot[k+1].rdy_in;
      end

      pipe_slot #(
        .WIDTH  (WIDTH),
        .SKID   (SKID),
        .BUBBLE (BUBBLE)
      ) u_slot (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (valid_b[k]),
        .in_ready   (rdy_in),
        .in_data    (data_b[k]),
        .out_valid  (valid_b[k+1]),
        .out_ready  (rdy_out),
        .out_data   (data_b[k+1]),
        .slot_state (st[k])
      );
    end

    assign in_ready = g_slot[0].rdy_in;

    // State encoding equals entries held, so occupancy is a plain sum.
    always_comb begin
      int sum;
      sum = 0;
      for (int k = 0; k < DEPTH; k++) begin
        sum = sum + int'(st[k]);
      end
      occupancy = OCC_W'(sum);
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic
// Directed bench for pipe_stage_elastic with four instances sharing clock
// and reset:
//   u_a : DEPTH=3 SKID=1 BUBBLE=0x13 (streaming, flush, reset mid-stream)
//   u_b : DEPTH=2 SKID=1             (back-pressure)
//   u_c : DEPTH=2 SKID=0             (combinational ready)
//   u_d : DEPTH=0                    (pass-through)
module tb_pipe_stage_elastic;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  logic        fl_a, iv_a, ir_a, ov_a, or_a;
  logic [31:0] id_a, od_a;
  logic [2:0]  occ_a;
  logic        fl_b, iv_b, ir_b, ov_b, or_b;
  logic [31:0] id_b, od_b;
  logic [2:0]  occ_b;
  logic        fl_c, iv_c, ir_c, ov_c, or_c;
  logic [31:0] id_c, od_c;
  logic [1:0]  occ_c;
  logic        fl_d, iv_d, ir_d, ov_d, or_d;
  logic [31:0] id_d, od_d;
  logic [0:0]  occ_d;

  pipe_stage_elastic #(.WIDTH(32), .DEPTH(3), .SKID(1), .BUBBLE(32'h13)) u_a (
    .clock(clock), .reset(reset), .flush(fl_a),
    .in_valid(iv_a), .in_ready(ir_a), .in_data(id_a),
    .out_valid(ov_a), .out_ready(or_a), .out_data(od_a), .occupancy(occ_a));

  pipe_stage_elastic #(.WIDTH(32), .DEPTH(2), .SKID(1), .BUBBLE(32'h0)) u_b (
    .clock(clock), .reset(reset), .flush(fl_b),
    .in_valid(iv_b), .in_ready(ir_b), .in_data(id_b),
    .out_valid(ov_b), .out_ready(or_b), .out_data(od_b), .occupancy(occ_b));

  pipe_stage_elastic #(.WIDTH(32), .DEPTH(2), .SKID(0), .BUBBLE(32'h0)) u_c (
    .clock(clock), .reset(reset), .flush(fl_c),
    .in_valid(iv_c), .in_ready(ir_c), .in_data(id_c),
    .out_valid(ov_c), .out_ready(or_c), .out_data(od_c), .occupancy(occ_c));

  pipe_stage_elastic #(.WIDTH(32), .DEPTH(0), .SKID(1), .BUBBLE(32'h13)) u_d (
    .clock(clock), .reset(reset), .flush(fl_d),
    .in_valid(iv_d), .in_ready(ir_d), .in_data(id_d),
    .out_valid(ov_d), .out_ready(or_d), .out_data(od_d), .occupancy(occ_d));

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic check_pass_through();
    for (int i = 0; i < 4; i++) begin
      iv_d = i[0];
      or_d = i[1];
      fl_d = i[0] ^ i[1];
      id_d = 32'hA5A5_0000 + 32'(i);
      #1;
      chk_val("d0_ov", 32'(ov_d), 32'(iv_d));
      chk_val("d0_ir", 32'(ir_d), 32'(or_d));
      chk_val("d0_od", od_d, id_d);
      chk_val("d0_occ", 32'(occ_d), 32'd0);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int exp_n;
    int exp_ir;
    fl_a = 0; iv_a = 0; or_a = 0; id_a = '0;
    fl_b = 0; iv_b = 0; or_b = 0; id_b = '0;
    fl_c = 0; iv_c = 0; or_c = 0; id_c = '0;
    fl_d = 0; iv_d = 0; or_d = 0; id_d = '0;

    // reset state
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk_val("rst_ov", 32'(ov_a), 32'd0);
    chk_val("rst_od", od_a, 32'h13);
    chk_val("rst_occ", 32'(occ_a), 32'd0);
    chk_val("rst_ir", 32'(ir_a), 32'd0);
    #2 reset = 1'b0;
    #1;
    chk_val("rel_ir", 32'(ir_a), 32'd1);
    next_cycle();

    // streaming, DEPTH=3 SKID=1: words 1..16, out_ready=1
    or_a = 1'b1;
    for (int c = 0; c < 20; c++) begin
      iv_a = (c < 16);
      id_a = (c < 16) ? 32'(c + 1) : 32'h0;
      #1;
      if (c < 16) chk_val("strm_ir", 32'(ir_a), 32'd1);
      chk_val("strm_ov", 32'(ov_a), 32'((c >= 3) && (c <= 18)));
      chk_val("strm_od", od_a, ((c >= 3) && (c <= 18)) ? 32'(c - 2) : 32'h13);
      next_cycle();
    end
    iv_a = 1'b0;
    chk_val("strm_occ_end", 32'(occ_a), 32'd0);

    // back-pressure, DEPTH=2 SKID=1
    or_b = 1'b0;
    k = 1;
    for (int it = 0; it < 6; it++) begin
      iv_b = 1'b1;
      id_b = 32'(k);
      #1;
      chk_val("bp_ir", 32'(ir_b), 32'(it < 4));
      if (it < 4) k++;
      next_cycle();
    end
    chk_val("bp_occ", 32'(occ_b), 32'd4);
    or_b = 1'b1;
    exp_n = 1;
    for (int it = 0; it < 30; it++) begin
      iv_b = (k <= 6);
      id_b = 32'(k);
      #1;
      if (ov_b) begin
        chk_val("bp_od", od_b, 32'(exp_n));
        exp_n++;
      end
      if (iv_b && ir_b) k++;
      next_cycle();
    end
    iv_b = 1'b0;
    chk_val("bp_cnt", 32'(exp_n), 32'd7);
    chk_val("bp_acc", 32'(k), 32'd7);

    // SKID=0 DEPTH=2: out_ready toggles, input continuous
    k = 1;
    for (int it = 0; it < 12; it++) begin
      or_c = it[0];
      iv_c = 1'b1;
      id_c = 32'(k);
      exp_ir = (it < 2) ? 1 : it % 2;
      #1;
      chk_val("s0_ir", 32'(ir_c), 32'(exp_ir));
      chk_val("s0_ov", 32'(ov_c), 32'(it >= 2));
      chk_val("s0_od", od_c, (it >= 2) ? 32'(it / 2) : 32'h0);
      chk_val("s0_occ", 32'(occ_c), (it == 0) ? 32'd0 : (it == 1) ? 32'd1 : 32'd2);
      if (exp_ir != 0) k++;
      next_cycle();
    end
    iv_c = 1'b0;
    or_c = 1'b0;

    // flush, DEPTH=3 SKID=1: fill to 5 with out_ready=0, flush with in_valid=1
    or_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      iv_a = 1'b1;
      id_a = 32'h200 + 32'(i);
      #1;
      chk_val("fl_fill_ir", 32'(ir_a), 32'd1);
      next_cycle();
    end
    fl_a = 1'b1;
    iv_a = 1'b1;
    id_a = 32'h2FF;
    #1;
    chk_val("fl_pre_occ", 32'(occ_a), 32'd5);
    chk_val("fl_ir", 32'(ir_a), 32'd0);
    chk_val("fl_ov_hold", 32'(ov_a), 32'd1);
    chk_val("fl_od_hold", od_a, 32'h200);
    next_cycle();
    fl_a = 1'b0;
    iv_a = 1'b0;
    #1;
    chk_val("fl_occ", 32'(occ_a), 32'd0);
    chk_val("fl_ov", 32'(ov_a), 32'd0);
    chk_val("fl_od", od_a, 32'h13);
    chk_val("fl_ir_after", 32'(ir_a), 32'd1);
    next_cycle();

    // DEPTH=0 out of reset, flush toggling
    check_pass_through();

    // reset mid-stream with occupancy=3
    for (int i = 0; i < 3; i++) begin
      iv_a = 1'b1;
      id_a = 32'h300 + 32'(i);
      #1;
      next_cycle();
    end
    iv_a = 1'b0;
    #1;
    chk_val("mr_pre_occ", 32'(occ_a), 32'd3);
    chk_val("mr_pre_ov", 32'(ov_a), 32'd1);
    reset = 1'b1;
    #1;
    chk_val("mr_ov", 32'(ov_a), 32'd0);
    chk_val("mr_occ", 32'(occ_a), 32'd0);
    chk_val("mr_ir", 32'(ir_a), 32'd0);
    chk_val("mr_od", od_a, 32'h13);
    check_pass_through();
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    chk_val("mr_rel_ir", 32'(ir_a), 32'd1);
    next_cycle();
    or_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      iv_a = (i == 0);
      id_a = (i == 0) ? 32'h55 : 32'h0;
      #1;
      chk_val("mr_post_ov", 32'(ov_a), 32'(i == 3));
      chk_val("mr_post_od", od_a, (i == 3) ? 32'h55 : 32'h13);
      next_cycle();
    end
    iv_a = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
